sbox_substitution_serial: RTL
=============================

SBOX_SUBSTITUTION_SERIAL -- requirements
Module: sbox_substitution_serial

Interface
REQ-001 SHALL have parameter: SBOXES_PER_CYCLE, default 1, number of S-boxes evaluated per RUN cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have ports (bit 1 = MSB on all buses, FIPS 46-3 numbering):
  clk  input  1  sole clock, rising edge
  reset  input  1  synchronous, active-high reset
  in_valid  input  1  expanded/round_key present
  in_ready  output  1  block can accept a job
  expanded  input  [1:48]  E-permutation output of right half
  round_key  input  [1:48]  round subkey K(n)
  out_valid  output  1  sbox_out holds a finished result
  out_ready  input  1  consumer accepts sbox_out
  sbox_out  output  [1:32]  S1..S8 substitution result, pre-P-permutation
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL drive every output from a register.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DONE.
REQ-006 IDLE: in_ready=1, out_valid=0; when in_valid=1, accept in that cycle: register x = expanded XOR round_key, clear sbox_out to 0, clear group index to 0, go to RUN.
REQ-007 SHALL sample expanded/round_key only in the accept cycle; later input changes SHALL NOT affect the result.
REQ-008 in_valid while in_ready=0 SHALL be ignored; no queueing.
REQ-009 RUN: each cycle evaluates S-boxes j = idx+1 .. idx+SBOXES_PER_CYCLE, then idx += SBOXES_PER_CYCLE; in_ready=0, out_valid=0.
REQ-010 Group j input SHALL be x[6j-5:6j]; row = {x[6j-5], x[6j]}, column = x[6j-4:6j-1]; 4-bit S_j(row,col) per FIPS 46-3 tables SHALL be written to sbox_out[4j-3:4j].
REQ-011 After the cycle that evaluates S8, the FSM SHALL go to DONE; RUN lasts exactly 8/SBOXES_PER_CYCLE cycles.
REQ-012 Latency: out_valid SHALL first be 1 exactly 8/SBOXES_PER_CYCLE+1 cycles after the accept cycle (9 for default).
REQ-013 DONE: out_valid=1, in_ready=0, sbox_out stable; when out_ready=1, go to IDLE (out_valid=0, in_ready=1 next cycle).
REQ-014 out_ready=0 in DONE SHALL hold state and sbox_out indefinitely.
REQ-015 out_ready outside DONE SHALL be ignored.
REQ-016 Minimum issue interval: 8/SBOXES_PER_CYCLE+2 cycles per job; no accept in the same cycle as output handshake.
REQ-017 Group index SHALL never exceed 8; it is not used outside RUN.
REQ-018 An illegal SBOXES_PER_CYCLE SHALL cause an elaboration-time error.

Reset
REQ-019 reset=1 at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, sbox_out=0, x=0, idx=0.
REQ-020 reset SHALL take priority over every handshake, including an accept or out handshake in the same cycle.
REQ-021 reset during RUN or DONE SHALL abandon the job; no out_valid for it afterward.

Verification
REQ-022 expanded=0, round_key=0, in_valid pulse -> sbox_out=0xEFA72C4D with out_valid rising 9 cycles after accept (default parameter).
REQ-023 expanded=0xFFFFFFFFFFFF, round_key=0 -> 0xD9CE3DCB; same expanded with round_key=0xFFFFFFFFFFFF -> 0xEFA72C4D.
REQ-024 expanded=0x6C0000000000, round_key=0 (S1 input 011011) -> 0x5FA72C4D.
REQ-025 Hold out_ready=0 for 10 cycles in DONE, toggle in_valid/expanded meanwhile -> out_valid and sbox_out constant, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
REQ-026 Assert reset in the 4th RUN cycle -> next cycle in_ready=1, out_valid=0, sbox_out=0; new job then completes normally.
REQ-027 Repeat REQ-022..REQ-024 for SBOXES_PER_CYCLE = 2, 4, 8 -> identical values, latencies 5, 3, 2.

Source files
------------

// File: rtl/sbox_substitution_serial.sv
// DES S-box substitution stage, evaluated serially over several cycles.
// Registers x = expanded ^ round_key when a job is accepted, then evaluates
// SBOXES_PER_CYCLE S-boxes per RUN cycle until S1..S8 are done.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   job handshake; expanded and round_key sampled on accept
//   expanded[1:48]      E-permutation output (bit 1 = MSB)
//   round_key[1:48]     round subkey (bit 1 = MSB)
//   out_valid/out_ready result handshake
//   sbox_out[1:32]      S1..S8 result, S1 in bits 1..4, pre-P-permutation
module sbox_substitution_serial #(
  parameter int unsigned SBOXES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:48] expanded,
  input  logic [1:48] round_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] sbox_out
);

  // Reject unsupported group sizes at elaboration.
  generate
    if (!(SBOXES_PER_CYCLE == 1 || SBOXES_PER_CYCLE == 2 ||
          SBOXES_PER_CYCLE == 4 || SBOXES_PER_CYCLE == 8)) begin : g_bad_param
      $error("sbox_substitution_serial: SBOXES_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam int unsigned NUM_SBOX = 8;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned X_W      = 48;
  localparam int unsigned OUT_W    = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // One row-major table per S-box: entry (row*16 + col) is nibble 0 at the MSB end.
  localparam logic [255:0] SBOX_TBL [NUM_SBOX] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Row is the outer bit pair, column the inner four bits.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [5:0] six);
    logic [5:0] pos;
    pos = {six[5], six[0], six[4:1]};
    return SBOX_TBL[sel][8'(255 - 4 * int'(pos)) -: 4];
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [OUT_W-1:0]   sbox_q, sbox_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         grp;
  logic [5:0]         six;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    sbox_d  = sbox_q;
    grp     = '0;
    six     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = expanded ^ round_key;
          sbox_d  = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Group grp (0-based) occupies x bits counted from the MSB end.
        for (int unsigned k = 0; k < SBOXES_PER_CYCLE; k++) begin
          grp = idx_q[2:0] + 3'(k);
          six = x_q[6'(47 - 6 * int'(grp)) -: 6];
          sbox_d[5'(31 - 4 * int'(grp)) -: 4] = sbox_lookup(grp, six);
        end
        idx_d = idx_q + IDX_W'(SBOXES_PER_CYCLE);
        if (idx_d == IDX_W'(NUM_SBOX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      sbox_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      sbox_q      <= sbox_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sbox_out  = sbox_q;

endmodule
